dsi_video_timing_gen: RTL and testbench
=======================================

# dsi_video_timing_gen

Generates the DPI-style video timing stream for the DSI video path: HSYNC, VSYNC, their sync-start strobes (HSYNC_plus, VSYNC_plus), DATA_ENB and a deterministic pixel pattern on DATA.
- Drives the signals that the DSI packetizer consumes and that the timing assertion checker monitors.
- Sits at the head of the video pipeline as the pixel source for bring-up and regression.
- All horizontal and vertical intervals are parameters; all outputs are registered.

## Interface
- H_SYNC, 4: HSYNC width in pixel clocks
- H_BP, 6: horizontal back porch
- H_ACTIVE, 16: active pixels per line
- H_FP, 4: horizontal front porch
- V_SYNC, 4: VSYNC width in lines
- V_BP, 4: vertical back porch in lines
- V_ACTIVE, 8: active lines per frame
- V_FP, 2: vertical front porch in lines
- DATA_W, 32: DATA width, must be >= 32
- pixel_clk  in  1  pixel clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run request, level-sensitive
- VSYNC  out  1  vertical sync, active-high
- HSYNC  out  1  horizontal sync, active-high
- VSYNC_plus  out  1  one-cycle strobe on the first cycle of VSYNC
- HSYNC_plus  out  1  one-cycle strobe on the first cycle of every HSYNC
- DATA_ENB  out  1  active-pixel qualifier
- DATA  out  DATA_W  pixel data; zero when DATA_ENB is low
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse on the last cycle of a frame

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters (30 with defaults). V_TOTAL = sum of the V_* parameters (18 with defaults).
- Elaboration `$error` if any interval is 0, if H_TOTAL or V_TOTAL exceeds 65535, or if DATA_W < 32.
- State machine with two states:
  - IDLE: counters are held at 0 and all outputs are 0.
  - RUN: counters run.
- Transitions:
  - IDLE -> RUN when en = 1.
  - At the end of a frame (h = H_TOTAL-1, v = V_TOTAL-1): stay in RUN if en = 1, otherwise go to IDLE.
- en is sampled only in IDLE and at frame end. Deasserting en mid-frame never truncates a frame.
- h counts 0..H_TOTAL-1 and wraps. v increments when h wraps, counts 0..V_TOTAL-1 and wraps.
- Output decode, from the counter values:
  - HSYNC = h < H_SYNC, on every line including vertical blanking.
  - HSYNC_plus = (h == 0).
  - VSYNC = v < V_SYNC.
  - VSYNC_plus = (h == 0 && v == 0).
  - DATA_ENB = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) && v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - DATA = zero-extended {line_idx[15:0], pix_idx[15:0]}, where both indices are active-relative and start at 0. DATA = 0 outside active.
  - frame_done = (h == H_TOTAL-1 && v == V_TOTAL-1).
  - busy = RUN.
- Reset values: every output is 0, the state is IDLE and h = v = 0.

## Timing
- Latency: en sampled high in IDLE at edge N, so first HSYNC/VSYNC/HSYNC_plus/VSYNC_plus = 1 at edge N+1.
- Outputs are registered and change only on posedge pixel_clk.
- Frame period is H_TOTAL × V_TOTAL = 540 cycles with defaults.
- Back-to-back frames have no gap: the cycle after frame_done shows VSYNC_plus = 1.
- After the final frame, the cycle after frame_done has all outputs at 0.
- Reset mid-frame (rst = 1 at any edge): all outputs are 0 at that edge, and the counters and state clear.
  - rst has priority over en.
  - A later en restarts at h = v = 0.
- en toggling within a frame has no effect on that frame.

## Structure
- Package dsi_video_pkg holds:
  - the state enum (IDLE, RUN)
  - the default timing constants
  - a typedef for the 16-bit counter type
  - a function computing the totals
- One sub-module, dsi_timing_counter: a parameterized wrap counter with enable, clear and a wrap output. It is instantiated once for h and once for v (v enabled by the h wrap).
- The top level holds the state machine and the registered decode.

## Test plan
- Reset: hold rst = 1 for 3 cycles with en = 1 -> all outputs 0 and busy = 0 throughout; rst released with en = 1 -> VSYNC_plus = 1 on the next cycle.
- Sync shape: start from IDLE -> HSYNC high 4 cycles out of every 30 and HSYNC_plus once per 30 cycles; VSYNC high for 120 consecutive cycles; VSYNC_plus exactly once per frame.
- Active data:
  - first DATA_ENB arrives 250 cycles after VSYNC_plus (8 lines, 10 pixels) with DATA = 0x0000_0000;
  - the end of that line has DATA = 0x0000_000F;
  - the last active pixel has DATA = 0x0007_000F;
  - 128 DATA_ENB cycles per frame.
- Continuous: en held high for 3 frames -> frame_done at cycles 540, 1080 and 1620 after start; each is followed immediately by VSYNC_plus.
- en dropped at line 5 -> the frame completes through frame_done, then all outputs are 0 and busy = 0.
- rst asserted at v = 10, h = 12 -> outputs 0 at that edge; en re-raised -> the new frame starts at VSYNC_plus with DATA restarting at 0x0000_0000.

Source files
------------

// File: rtl/dsi_video_pkg.sv
// Shared types and default timing for the DSI video timing generator.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package dsi_video_pkg;

    // Two-state run control: IDLE holds everything at zero, RUN advances the raster.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Raster position counters are 16 bits, so each total must fit in 65535.
    typedef logic [15:0] cnt_t;

    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 6;
    localparam int DEF_H_ACTIVE = 16;
    localparam int DEF_H_FP     = 4;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 4;
    localparam int DEF_V_ACTIVE = 8;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_DATA_W   = 32;

    // Total period of one axis: sync + back porch + active + front porch.
    function automatic int timing_total(input int sync_w, input int bp,
                                        input int active, input int fp);
        return sync_w + bp + active + fp;
    endfunction

endpackage

// File: rtl/dsi_timing_counter.sv
// Wrap counter 0..MAX-1 with enable, synchronous clear and a wrap flag.
// Latency: count updates one cycle after en; wrap is combinational from count and en.
// Backpressure: none; en is the only advance qualifier.
module dsi_timing_counter
    import dsi_video_pkg::*;
#(
    parameter int MAX = 30
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output cnt_t cnt,
    output logic wrap
);

    localparam cnt_t LAST = cnt_t'(MAX - 1);

    // Wrap is asserted on the advancing cycle that returns the count to zero.
    assign wrap = en && (cnt == LAST);

    // Count register: reset/clear win, otherwise advance and wrap at LAST.
    always_ff @(posedge pixel_clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + cnt_t'(1);
        end
    end

endmodule

// File: rtl/dsi_video_timing_gen.sv
// DPI-style video timing source: HSYNC/VSYNC, sync strobes, DATA_ENB and a pixel-index pattern.
// Latency: en seen in IDLE at edge N gives the first sync outputs at edge N+1; all outputs registered.
// Backpressure: none; frames run to completion once started, en is only sampled in IDLE and at frame end.
module dsi_video_timing_gen
    import dsi_video_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              en,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic              VSYNC_plus,
    output logic              HSYNC_plus,
    output logic              DATA_ENB,
    output logic [DATA_W-1:0] DATA,
    output logic              busy,
    output logic              frame_done
);

    localparam int H_TOTAL = timing_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = timing_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    if (H_SYNC == 0 || H_BP == 0 || H_ACTIVE == 0 || H_FP == 0 ||
        V_SYNC == 0 || V_BP == 0 || V_ACTIVE == 0 || V_FP == 0) begin : g_bad_interval
        $error("dsi_video_timing_gen: every timing interval must be non-zero");
    end
    if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_total
        $error("dsi_video_timing_gen: H_TOTAL and V_TOTAL must fit in 16 bits");
    end
    if (DATA_W < 32) begin : g_bad_width
        $error("dsi_video_timing_gen: DATA_W must be at least 32");
    end

    // Window edges in counter units (active windows are half-open).
    localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
    localparam cnt_t H_ACT_START = cnt_t'(H_SYNC + H_BP);
    localparam cnt_t H_ACT_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
    localparam cnt_t V_ACT_START = cnt_t'(V_SYNC + V_BP);
    localparam cnt_t V_ACT_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);

    state_t state_q;
    state_t state_d;

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_wrap;
    logic v_wrap;
    logic running;

    logic              enb_nxt;
    logic [DATA_W-1:0] data_nxt;

    assign running = (state_q == RUN);

    dsi_timing_counter #(.MAX(H_TOTAL)) u_h_cnt (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .clr       (!running),
        .en        (running),
        .cnt       (h_cnt),
        .wrap      (h_wrap)
    );

    // The line counter advances on each horizontal wrap; its own wrap marks frame end.
    dsi_timing_counter #(.MAX(V_TOTAL)) u_v_cnt (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .clr       (!running),
        .en        (h_wrap),
        .cnt       (v_cnt),
        .wrap      (v_wrap)
    );

    // Run control: start on en from IDLE, and only re-check en at the last cycle of a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (v_wrap && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset overrides any pending start.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Active-window qualifier and the {line, pixel} index pattern for the current position.
    always_comb begin
        enb_nxt  = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
                   (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
        data_nxt = '0;
        if (enb_nxt) begin
            data_nxt[31:0] = {v_cnt - V_ACT_START, h_cnt - H_ACT_START};
        end
    end

    // Registered decode of the raster position; everything is zero outside RUN.
    always_ff @(posedge pixel_clk) begin
        if (rst || !running) begin
            VSYNC      <= 1'b0;
            HSYNC      <= 1'b0;
            VSYNC_plus <= 1'b0;
            HSYNC_plus <= 1'b0;
            DATA_ENB   <= 1'b0;
            DATA       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            VSYNC      <= (v_cnt < V_SYNC_END);
            HSYNC      <= (h_cnt < H_SYNC_END);
            VSYNC_plus <= (h_cnt == '0) && (v_cnt == '0);
            HSYNC_plus <= (h_cnt == '0);
            DATA_ENB   <= enb_nxt;
            DATA       <= data_nxt;
            busy       <= 1'b1;
            frame_done <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
        end
    end

endmodule

// File: tb/tb_dsi_video_timing_gen.sv
// Scoreboard bench for dsi_video_timing_gen: per-edge expected outputs from a frame-position model.
// Latency: model output for edge N is compared at the following negedge.
// Backpressure: n/a.
module tb_dsi_video_timing_gen;

    localparam int HS = 4, HB = 6, HA = 16, HF = 4;
    localparam int VS = 4, VB = 4, VA = 8, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        vsync;
        logic        hsync;
        logic        vsync_plus;
        logic        hsync_plus;
        logic        data_enb;
        logic        busy;
        logic        frame_done;
        logic [31:0] data;
    } obs_t;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        VSYNC, HSYNC, VSYNC_plus, HSYNC_plus, DATA_ENB, busy, frame_done;
    logic [31:0] DATA;

    int checks = 0;
    int errors = 0;

    obs_t exp_q[$];

    // Reference model: frame position k in 0..FRAME-1 plus a running flag.
    bit running = 1'b0;
    int k = 0;
    int model_frames = 0;
    int model_vplus = 0;
    int seen_frames = 0;
    int seen_vplus = 0;

    dsi_video_timing_gen dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .en         (en),
        .VSYNC      (VSYNC),
        .HSYNC      (HSYNC),
        .VSYNC_plus (VSYNC_plus),
        .HSYNC_plus (HSYNC_plus),
        .DATA_ENB   (DATA_ENB),
        .DATA       (DATA),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic obs_t frame_point(input int pos);
        obs_t o;
        int h, v;
        h = pos % HT;
        v = pos / HT;
        o = '0;
        o.busy       = 1'b1;
        o.hsync      = (h < HS);
        o.vsync      = (v < VS);
        o.hsync_plus = (h == 0);
        o.vsync_plus = (pos == 0);
        o.frame_done = (pos == FRAME - 1);
        o.data_enb   = (h >= HS + HB) && (h < HS + HB + HA) &&
                       (v >= VS + VB) && (v < VS + VB + VA);
        if (o.data_enb) begin
            o.data[31:16] = 16'(v - (VS + VB));
            o.data[15:0]  = 16'(h - (HS + HB));
        end
        return o;
    endfunction

    // One clock edge with the given inputs; the model predicts what that edge registers.
    task automatic step(input logic e, input logic r);
        obs_t x;
        en  = e;
        rst = r;
        @(posedge pixel_clk);
        #1;
        x = '0;
        if (r) begin
            running = 1'b0;
            k = 0;
        end else if (!running) begin
            if (e) begin
                running = 1'b1;
                k = 0;
            end
        end else begin
            x = frame_point(k);
            if (x.vsync_plus) model_vplus++;
            if (k == FRAME - 1) begin
                model_frames++;
                k = 0;
                running = e;
            end else begin
                k++;
            end
        end
        exp_q.push_back(x);
    endtask

    // Monitor: compare every registered output sample, plus event-relative sanity checks.
    int since_vp = -1;
    int enb_cnt = 0;
    bit first_enb = 1'b0;
    initial begin
        obs_t act, e;
        forever begin
            @(negedge pixel_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act = {VSYNC, HSYNC, VSYNC_plus, HSYNC_plus, DATA_ENB, busy, frame_done, DATA};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got vs=%b hs=%b vp=%b hp=%b de=%b busy=%b fd=%b data=%h exp vs=%b hs=%b vp=%b hp=%b de=%b busy=%b fd=%b data=%h",
                             $time, act.vsync, act.hsync, act.vsync_plus, act.hsync_plus, act.data_enb,
                             act.busy, act.frame_done, act.data, e.vsync, e.hsync, e.vsync_plus,
                             e.hsync_plus, e.data_enb, e.busy, e.frame_done, e.data);
                end
                if (!busy) begin
                    since_vp = -1;
                end else if (VSYNC_plus) begin
                    since_vp = 0;
                    enb_cnt = 0;
                    first_enb = 1'b0;
                    seen_vplus++;
                end else if (since_vp >= 0) begin
                    since_vp++;
                end
                if (DATA_ENB && since_vp >= 0) begin
                    enb_cnt++;
                    if (!first_enb) begin
                        first_enb = 1'b1;
                        checks++;
                        if (since_vp != 250 || DATA !== 32'h0) begin
                            errors++;
                            $display("FAIL first_active got offset=%0d data=%h exp offset=250 data=00000000", since_vp, DATA);
                        end
                    end
                    if (since_vp == 265) begin
                        checks++;
                        if (DATA !== 32'h0000_000F) begin
                            errors++;
                            $display("FAIL first_line_end got %h exp 0000000f", DATA);
                        end
                    end
                    if (since_vp == 475) begin
                        checks++;
                        if (DATA !== 32'h0007_000F) begin
                            errors++;
                            $display("FAIL last_active got %h exp 0007000f", DATA);
                        end
                    end
                end
                if (frame_done) begin
                    seen_frames++;
                    checks++;
                    if (since_vp != FRAME - 1 || enb_cnt != HA * VA) begin
                        errors++;
                        $display("FAIL frame_shape got len=%0d enb=%0d exp len=%0d enb=%0d",
                                 since_vp + 1, enb_cnt, FRAME, HA * VA);
                    end
                end
            end
        end
    end

    initial begin
        // Reset held with en high: outputs must stay zero.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        // Three back-to-back frames, then en dropped during line 5 of the fourth.
        for (int i = 0; i < 1 + 3 * FRAME + 5 * HT; i++) step(1'b1, 1'b0);
        for (int i = 0; i < FRAME - 5 * HT + 20; i++) step(1'b0, 1'b0);
        // Restart, reset at v=10 h=12, then restart again.
        step(1'b1, 1'b0);
        for (int i = 0; i < 10 * HT + 12; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        for (int i = 0; i < FRAME + 10; i++) step(1'b1, 1'b0);
        // Random en activity with rare resets; en toggling inside a frame must not matter.
        for (int i = 0; i < 5000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1999) == 0));
        end
        for (int i = 0; i < FRAME + 5; i++) step(1'b0, 1'b0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        checks++;
        if (seen_frames != model_frames || model_frames < 4) begin
            errors++;
            $display("FAIL frame_count got %0d exp %0d", seen_frames, model_frames);
        end
        checks++;
        if (seen_vplus != model_vplus) begin
            errors++;
            $display("FAIL vsync_plus_count got %0d exp %0d", seen_vplus, model_vplus);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
